// File: rtl/regfile_mp_pkg.sv
// Shared widths, FSM encoding and lane-packing helpers for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_mp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NRD    = 2;
    localparam int DEF_NWR    = 2;

    // First entry touched by the clear walk; entry 0 is hardwired zero.
    localparam int CLR_START  = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_t;

    // Low bit of lane idx in a flat bus of w-bit lanes.
    function automatic int lane_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// One read port: selects same-cycle write data (highest-index writer wins) over the stored word.
// Latency: combinational.
// Backpressure: none; output forced to zero while disabled, addressing entry 0, or clearing.
module regfile_bypass
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NWR    = DEF_NWR
) (
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic                     busy,
    input  logic [NWR-1:0]           we,
    input  logic [NWR*ADDR_W-1:0]    waddr,
    input  logic [NWR*DATA_W-1:0]    wdata,
    input  logic [DATA_W-1:0]        stored,
    output logic [DATA_W-1:0]        rdata
);

    // Later ports overwrite earlier matches so the highest-index writer is forwarded;
    // the zero-address gate also excludes writes aimed at entry 0 from forwarding.
    always_comb begin
        rdata = stored;
        for (int k = 0; k < NWR; k++) begin
            if (we[k] && (waddr[lane_lo(k, ADDR_W) +: ADDR_W] == raddr)) begin
                rdata = wdata[lane_lo(k, DATA_W) +: DATA_W];
            end
        end
        if (!re || (raddr == '0) || busy) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, pending-result scoreboard and sequential clear.
// Latency: reads combinational (same-cycle bypass); writes commit on the next rising edge.
// Backpressure: busy high during clear; writes and scoreboard sets presented then are dropped.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = DEF_NRD,
    parameter int NWR    = DEF_NWR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     busy,
    input  logic [NWR-1:0]           we,
    input  logic [NWR*ADDR_W-1:0]    waddr,
    input  logic [NWR*DATA_W-1:0]    wdata,
    input  logic [NRD-1:0]           re,
    input  logic [NRD*ADDR_W-1:0]    raddr,
    output logic [NRD*DATA_W-1:0]    rdata,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic [NRD-1:0]           rd_pend
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(CLR_START);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

    rf_state_t             state_q, state_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic                  clr_enter;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]      pend_q;

    assign busy = (state_q == ST_CLEAR);

    // State and clear-walk pointer; reset always (re)starts the walk at entry 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= CLR_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: clr_req only honoured from IDLE; the walk ends on the edge that zeroes the last entry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_enter = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    cnt_d     = CLR_FIRST;
                    clr_enter = 1'b1;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage: clear walk owns the array while busy; otherwise ascending port order lets the highest port win.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (waddr[lane_lo(k, ADDR_W) +: ADDR_W] != '0)) begin
                    mem[waddr[lane_lo(k, ADDR_W) +: ADDR_W]] <= wdata[lane_lo(k, DATA_W) +: DATA_W];
                end
            end
        end
    end

    // Scoreboard: committed writes retire pending bits, then a same-edge set overrides the retire.
    always_ff @(posedge clk) begin
        if (rst || clr_enter) begin
            pend_q <= '0;
        end else if (!busy) begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] && (waddr[lane_lo(k, ADDR_W) +: ADDR_W] != '0)) begin
                    pend_q[waddr[lane_lo(k, ADDR_W) +: ADDR_W]] <= 1'b0;
                end
            end
            if (sb_set && (sb_addr != '0)) begin
                pend_q[sb_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[i*ADDR_W +: ADDR_W];

        regfile_bypass #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_bypass (
            .re     (re[i]),
            .raddr  (ra),
            .busy   (busy),
            .we     (we),
            .waddr  (waddr),
            .wdata  (wdata),
            .stored (mem[ra]),
            .rdata  (rdata[i*DATA_W +: DATA_W])
        );

        assign rd_pend[i] = (ra != '0) && pend_q[ra];
    end

endmodule
